// File: rtl/stdaes_optimized_inv_key_expantion.sv
// -----------------------------------------------------------------------------
// stdaes_optimized_inv_key_expantion
//
// Iterative AES-128 decryption key scheduler. A cipher key is accepted in
// IDLE. The forward schedule then runs to round key 10, one round per cycle.
// After that the schedule is stepped backwards, presenting round keys 10..0
// one per handshake. The forward and inverse steps share one 32-bit SubWord
// (StdAES_Optimized_SubBytes) whose input is muxed by state.
//
// Ports
//   CLK        in   sole clock, rising edge
//   RST        in   synchronous active-high reset
//   key_in     in   128-bit cipher key (word 0 = [127:96], byte 0 = [127:120])
//   key_valid  in   key_in valid
//   key_ready  out  high only in IDLE
//   rk_out     out  current round key, same ordering as key_in
//   rk_idx     out  round number of rk_out (10 down to 0)
//   rk_valid   out  rk_out/rk_idx valid
//   rk_ready   in   consumer accepts on rk_valid & rk_ready
//   rk_last    out  rk_valid & (rk_idx == 0)
//   busy       out  state != IDLE
// -----------------------------------------------------------------------------

// Four parallel AES S-boxes (SubWord). Each S-box is computed as the GF(2^8)
// multiplicative inverse followed by the AES affine transform.
module StdAES_Optimized_SubBytes (
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0): the loop builds
  // a^3, a^7, ... a^127, then one final squaring gives a^254.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), a);
    end
    r = gf_mul(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    data_out = {sbox(data_in[31:24]), sbox(data_in[23:16]),
                sbox(data_in[15:8]),  sbox(data_in[7:0])};
  end

endmodule

module stdaes_optimized_inv_key_expantion (
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  state_t       state, state_nxt;
  logic [127:0] k, k_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic [7:0]   rcon, rcon_nxt;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_src, sub_in, sub_out;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  i0, i1, i2, i3;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return {1'b0, x[7:1]} ^ (x[0] ? 8'h8d : 8'h00);
  endfunction

  assign w0 = k[127:96];
  assign w1 = k[95:64];
  assign w2 = k[63:32];
  assign w3 = k[31:0];

  // In REV the previous round's w3 is recovered as w3 ^ w2 before SubWord.
  assign sub_src = (state == REV) ? (w3 ^ w2) : w3;
  assign sub_in  = {sub_src[23:0], sub_src[31:24]};

  StdAES_Optimized_SubBytes u_subword (
    .data_in  (sub_in),
    .data_out (sub_out)
  );

  // Forward round: next round key from the current one.
  assign f0 = w0 ^ sub_out ^ {rcon, 24'h0};
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  // Inverse round: previous round key from the current one.
  assign i3 = w3 ^ w2;
  assign i2 = w2 ^ w1;
  assign i1 = w1 ^ w0;
  assign i0 = w0 ^ sub_out ^ {rcon, 24'h0};

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    cnt_nxt   = cnt;
    rcon_nxt  = rcon;
    case (state)
      IDLE: begin
        if (key_valid) begin
          k_nxt     = key_in;
          cnt_nxt   = 4'd1;
          rcon_nxt  = 8'h01;
          state_nxt = FWD;
        end
      end
      FWD: begin
        k_nxt = {f0, f1, f2, f3};
        if (cnt == 4'd10) begin
          // rcon stays at 8'h36: it is exactly the constant needed to leave
          // round 10 in the reverse direction.
          state_nxt = REV;
        end else begin
          cnt_nxt  = cnt + 4'd1;
          rcon_nxt = xtime(rcon);
        end
      end
      REV: begin
        if (rk_ready) begin
          if (cnt != 4'd0) begin
            k_nxt    = {i0, i1, i2, i3};
            cnt_nxt  = cnt - 4'd1;
            rcon_nxt = inv_xtime(rcon);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      k     <= 128'h0;
      cnt   <= 4'd0;
      rcon  <= 8'h00;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      cnt   <= cnt_nxt;
      rcon  <= rcon_nxt;
    end
  end

  assign key_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rk_valid  = (state == REV);
  assign rk_last   = (state == REV) && (cnt == 4'd0);
  assign rk_out    = k;
  assign rk_idx    = cnt;

endmodule
